// File: rtl/btn_led_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// btn_led_pkg
//   Shared definitions for the button-driven LED sequencer:
//     mode_t        - 2-bit operating mode (OFF / ON / BLINK_SLOW / BLINK_FAST)
//     DEF_*         - default timing constants, in clk cycles
//     cnt_w()       - counter width for a terminal count (never below 1 bit)
//     next_mode()   - press-driven mode rotation
// ---------------------------------------------------------------------------
package btn_led_pkg;

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        ON         = 2'd1,
        BLINK_SLOW = 2'd2,
        BLINK_FAST = 2'd3
    } mode_t;

    localparam int DEF_DEBOUNCE_CYCLES   = 500000;
    localparam int DEF_BLINK_SLOW_CYCLES = 25000000;
    localparam int DEF_BLINK_FAST_CYCLES = 5000000;
    localparam int DEF_LONG_CYCLES       = 100000000;

    // $clog2(n) bits are enough to hold 0..n-1; a one-cycle count still
    // needs a physical bit.
    function automatic int cnt_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        unique case (m)
            OFF:        return ON;
            ON:         return BLINK_SLOW;
            BLINK_SLOW: return BLINK_FAST;
            default:    return OFF;
        endcase
    endfunction

endpackage

// File: rtl/btn_led_sequencer_if.sv
// ---------------------------------------------------------------------------
// btn_led_if
//   User-facing signal bundle of the sequencer.
//     btn          raw mechanical button, active-high, asynchronous to clk
//     led          registered LED drive
//     mode         current operating mode (mode_t)
//     press_pulse  one-cycle strobe per accepted press
//   Modports:
//     master - the side that owns the button and watches the indicators
//     slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface btn_led_if;
    import btn_led_pkg::*;

    logic  btn;
    logic  led;
    mode_t mode;
    logic  press_pulse;

    modport master (
        output btn,
        input  led,
        input  mode,
        input  press_pulse
    );

    modport slave (
        input  btn,
        output led,
        output mode,
        output press_pulse
    );

endinterface

// File: rtl/btn_led_sequencer_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Synchronises the raw button into the clk domain, filters contact bounce
//   and flags accepted presses.
//   Ports:
//     clk, rst_n   system clock, asynchronous active-low reset
//     btn          raw button input
//     stable       debounced button level
//     press_pulse  one-cycle strobe, high in the cycle right after stable
//                  goes 0->1; releases produce nothing
//   Parameter:
//     DEBOUNCE_CYCLES  consecutive disagreeing cycles needed to accept a
//                      new level
// ---------------------------------------------------------------------------
module btn_debounce
    import btn_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic stable,
    output logic press_pulse
);

    localparam int              DB_W    = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_p0;
    logic            sync_p1;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            stable      <= 1'b0;
            db_cnt      <= '0;
            press_pulse <= 1'b0;
        end else begin
            // stage p0/p1: two-flop synchroniser
            sync_p0     <= btn;
            sync_p1     <= sync_p0;
            press_pulse <= 1'b0;
            // any agreement restarts the run, so short glitches never land
            if (sync_p1 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_TERM) begin
                stable      <= sync_p1;
                db_cnt      <= '0;
                // strobe lines up with the first cycle stable reads 1
                press_pulse <= sync_p1;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_led_sequencer.sv
// ---------------------------------------------------------------------------
// btn_led_sequencer
//   Single-button LED controller. Each accepted press steps the mode
//   OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF. In the blink modes the LED
//   toggles every BLINK_*_CYCLES cycles, starting lit on entry.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    btn_led_if.slave: btn in; led, mode, press_pulse out
//   Parameters:
//     DEBOUNCE_CYCLES, BLINK_SLOW_CYCLES, BLINK_FAST_CYCLES, LONG_CYCLES
//   Build option:
//     BTN_LONG_PRESS_EN - when defined, holding the button for LONG_CYCLES
//     forces the sequencer to OFF (once per hold); otherwise hold time is
//     irrelevant.
// ---------------------------------------------------------------------------
module btn_led_sequencer
    import btn_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int BLINK_SLOW_CYCLES = DEF_BLINK_SLOW_CYCLES,
    parameter int BLINK_FAST_CYCLES = DEF_BLINK_FAST_CYCLES,
    parameter int LONG_CYCLES       = DEF_LONG_CYCLES
) (
    input logic    clk,
    input logic    rst_n,
    btn_led_if.slave bus
);

    // One prescaler serves both blink rates; it is sized for the longer one.
    localparam int BLINK_MAX = (BLINK_SLOW_CYCLES > BLINK_FAST_CYCLES) ?
                               BLINK_SLOW_CYCLES : BLINK_FAST_CYCLES;
    localparam int                 PRESC_W   = cnt_w(BLINK_MAX);
    localparam logic [PRESC_W-1:0] SLOW_TERM = PRESC_W'(BLINK_SLOW_CYCLES - 1);
    localparam logic [PRESC_W-1:0] FAST_TERM = PRESC_W'(BLINK_FAST_CYCLES - 1);

    logic stable;
    logic press_pulse;
    logic long_evt;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (bus.btn),
        .stable      (stable),
        .press_pulse (press_pulse)
    );

`ifdef BTN_LONG_PRESS_EN
    localparam int                HOLD_W    = cnt_w(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;

    // hold_done parks the counter at its terminal value until release, so
    // the forced OFF fires once per hold and the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else if (!stable) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else if (!hold_done) begin
            if (hold_cnt == HOLD_TERM) begin
                hold_done <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    assign long_evt = stable && !hold_done && (hold_cnt == HOLD_TERM);
`else
    logic unused_stable;

    assign unused_stable = stable & (LONG_CYCLES > 0);
    assign long_evt      = 1'b0;
`endif

    mode_t              mode_q;
    mode_t              mode_d;
    logic               led_q;
    logic               led_d;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic [PRESC_W-1:0] presc_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= OFF;
            led_q   <= 1'b0;
            presc_q <= '0;
        end else begin
            mode_q  <= mode_d;
            led_q   <= led_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        mode_d     = mode_q;
        led_d      = led_q;
        presc_d    = presc_q;
        presc_term = (mode_q == BLINK_FAST) ? FAST_TERM : SLOW_TERM;

        if (long_evt) begin
            // takes priority over a press landing in the same cycle
            mode_d  = OFF;
            led_d   = 1'b0;
            presc_d = '0;
        end else if (press_pulse) begin
            // every new mode except OFF starts with the LED lit and a fresh
            // prescaler, so slow->fast never inherits a partial count
            mode_d  = next_mode(mode_q);
            led_d   = (mode_d != OFF);
            presc_d = '0;
        end else begin
            unique case (mode_q)
                OFF: led_d = 1'b0;
                ON:  led_d = 1'b1;
                default: begin
                    if (presc_q == presc_term) begin
                        presc_d = '0;
                        led_d   = ~led_q;
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.led         = led_q;
    assign bus.mode        = mode_q;
    assign bus.press_pulse = press_pulse;

endmodule

// File: doc/btn_led_sequencer.md
BTN_LED_SEQUENCER -- requirements
Module: btn_led_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a button level change.
REQ-002 Parameter BLINK_SLOW_CYCLES, default 25000000: half-period of slow blink, in clk cycles.
REQ-003 Parameter BLINK_FAST_CYCLES, default 5000000: half-period of fast blink, in clk cycles.
REQ-004 Parameter LONG_CYCLES, default 100000000: hold time that counts as a long press, in clk cycles.
REQ-005 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port btn, input, 1: raw mechanical button, asynchronous to clk, active-high.
REQ-008 Port led, output, 1: registered LED drive.
REQ-009 Port mode, output, 2: current mode; 0=OFF, 1=ON, 2=BLINK_SLOW, 3=BLINK_FAST.
REQ-010 Port press_pulse, output, 1: one-cycle strobe per accepted press.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce: a counter SHALL increment while synced != stable and clear whenever they are equal; at DEBOUNCE_CYCLES-1 stable SHALL take the synced value and the counter SHALL clear.
REQ-013 Glitches shorter than DEBOUNCE_CYCLES SHALL NOT change stable.
REQ-014 press_pulse SHALL be high for exactly one cycle, in the cycle after stable rises 0->1; a falling edge of stable SHALL generate no event.
REQ-015 FSM states and transitions on press_pulse: OFF->ON->BLINK_SLOW->BLINK_FAST->OFF; with no press the state SHALL hold.
REQ-016 mode SHALL update on the clk edge that ends the press_pulse cycle (1-cycle latency from press_pulse).
REQ-017 led SHALL be 0 in OFF and 1 in ON, updating on the same edge as mode.
REQ-018 In blink modes a prescaler SHALL count 0..N-1 (N = BLINK_SLOW_CYCLES or BLINK_FAST_CYCLES) and toggle led at wrap; on entering any blink mode led SHALL be 1 and the prescaler 0.
REQ-019 The prescaler SHALL clear on every mode change; BLINK_SLOW->BLINK_FAST SHALL NOT carry the count over.
REQ-020 Counter widths SHALL be $clog2 of the respective parameter (minimum 1); no counter SHALL wrap past its terminal value.

Reset
REQ-021 On rst_n low, regardless of clk: synchronizer flops, stable, all counters, press_pulse, led SHALL be 0 and mode SHALL be OFF.
REQ-022 A press in progress when reset asserts SHALL be discarded. After release of reset, a button already held SHALL produce one press_pulse after debounce completes.

Configuration
REQ-023 Macro BTN_LONG_PRESS_EN. When defined, a hold counter SHALL count cycles with stable=1. At LONG_CYCLES it SHALL force mode=OFF and led=0 once per hold, and the release after that hold SHALL have no effect.
REQ-024 When BTN_LONG_PRESS_EN is undefined, the hold counter SHALL be absent and hold duration SHALL have no effect.
REQ-025 If a long-press threshold and a press_pulse fall in the same cycle, the long-press action SHALL win (mode=OFF).

Structure
REQ-026 Shared package btn_led_pkg SHALL hold the mode_t typedef (2-bit enum OFF/ON/BLINK_SLOW/BLINK_FAST) and the default timing constants.
REQ-027 Sub-module btn_debounce SHALL contain the synchronizer, debounce counter and rising-edge detector, outputting stable and press_pulse.

Verification (DEBOUNCE_CYCLES=4, BLINK_SLOW_CYCLES=8, BLINK_FAST_CYCLES=2, LONG_CYCLES=20)
REQ-028 Apply btn high for 3 cycles then low -> no press_pulse; mode stays 0; led stays 0.
REQ-029 Apply 4 clean presses of 10 cycles each, 10 cycles apart -> four single-cycle press_pulses; mode sequence 1,2,3,0; led 1 in ON.
REQ-030 In BLINK_SLOW, hold 40 cycles -> led=1 on entry, then toggles every 8 cycles. Press again -> BLINK_FAST, led=1, toggles every 2 cycles.
REQ-031 Assert rst_n=0 asynchronously mid-blink while btn is held -> led=0 and mode=0 immediately. After release, exactly one press_pulse occurs, 6 cycles after reset release (2 sync + 4 debounce).
REQ-032 With BTN_LONG_PRESS_EN, hold btn 30 cycles from mode=2 -> mode goes 3 at the press, then 0 when the 20-cycle hold threshold is reached; release causes no change. Without the macro, mode stays 3.
